// File: rtl/wb_regfile_unit.sv
// rtl/wb_regfile_unit.sv - writeback select and 32x32 register file with same-cycle read bypass
// Optional commit counter output WriteCount is enabled by WB_REGFILE_WRCOUNT_EN.
module wb_regfile_unit #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int LINK_REG = 31
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              WBmemtoreg,
   input  logic              WBregwrite,
   input  logic              WBcntrljalr,
   input  logic              WBcntrljald,
   input  logic [DATA_W-1:0] WBPCAddResult,
   input  logic [DATA_W-1:0] WBAluResult,
   input  logic [DATA_W-1:0] WBReadData,
   input  logic [ADDR_W-1:0] WBRegDst,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] WriteData,
   output logic [ADDR_W-1:0] WriteReg,
   output logic              WriteEn
`ifdef WB_REGFILE_WRCOUNT_EN
   ,
   output logic [31:0]       WriteCount
`endif
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_link;

   assign w_link = WBcntrljald | WBcntrljalr;

   always_comb begin
      WriteData = WBAluResult;
      if (w_link)
         WriteData = WBPCAddResult;
      else if (WBmemtoreg)
         WriteData = WBReadData;
   end

   assign WriteReg = WBcntrljald ? ADDR_W'(LINK_REG) : WBRegDst;
   // Strobe term is ANDed first so an X destination with no strobe still yields 0.
   assign WriteEn  = (WBregwrite | w_link) & (WriteReg != '0);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (WriteEn && (WriteReg == ADDR_W'(i)))
               r_regs[i] <= WriteData;
      end
   end

   always_comb begin
      ReadData1 = '0;
      if (Reset && (ReadRegister1 != '0)) begin
         if (WriteEn && (WriteReg == ReadRegister1))
            ReadData1 = WriteData;
         else
            ReadData1 = r_regs[ReadRegister1];
      end
   end

   always_comb begin
      ReadData2 = '0;
      if (Reset && (ReadRegister2 != '0)) begin
         if (WriteEn && (WriteReg == ReadRegister2))
            ReadData2 = WriteData;
         else
            ReadData2 = r_regs[ReadRegister2];
      end
   end

`ifdef WB_REGFILE_WRCOUNT_EN
   logic [31:0] r_wr_count;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         r_wr_count <= '0;
      else if (WriteEn)
         r_wr_count <= r_wr_count + 32'd1;
   end

   assign WriteCount = r_wr_count;
`endif

endmodule

// File: tb/tb_wb_regfile_unit.sv
// tb/tb_wb_regfile_unit.sv - directed self-checking bench for wb_regfile_unit
// Checks WriteCount as well when WB_REGFILE_WRCOUNT_EN is defined.
module tb_wb_regfile_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        WBmemtoreg, WBregwrite, WBcntrljalr, WBcntrljald;
   logic [31:0] WBPCAddResult, WBAluResult, WBReadData;
   logic [4:0]  WBRegDst, ReadRegister1, ReadRegister2;
   logic [31:0] ReadData1, ReadData2, WriteData;
   logic [4:0]  WriteReg;
   logic        WriteEn;
`ifdef WB_REGFILE_WRCOUNT_EN
   logic [31:0] WriteCount;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   wb_regfile_unit dut (
      .Clk(Clk), .Reset(Reset),
      .WBmemtoreg(WBmemtoreg), .WBregwrite(WBregwrite),
      .WBcntrljalr(WBcntrljalr), .WBcntrljald(WBcntrljald),
      .WBPCAddResult(WBPCAddResult), .WBAluResult(WBAluResult),
      .WBReadData(WBReadData), .WBRegDst(WBRegDst),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteData(WriteData), .WriteReg(WriteReg), .WriteEn(WriteEn)
`ifdef WB_REGFILE_WRCOUNT_EN
      , .WriteCount(WriteCount)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_count(input string tag, input logic [31:0] exp);
`ifdef WB_REGFILE_WRCOUNT_EN
      check(tag, WriteCount, exp);
`else
      if (exp === 32'hxxxx_xxxx) $display("unused %s", tag);
`endif
   endtask

   task automatic idle();
      WBmemtoreg = 0; WBregwrite = 0; WBcntrljalr = 0; WBcntrljald = 0;
      WBPCAddResult = 0; WBAluResult = 0; WBReadData = 0; WBRegDst = 0;
   endtask

   task automatic to_low_phase();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      idle();
      ReadRegister1 = 0; ReadRegister2 = 0;
      Reset = 0;
      repeat (2) @(posedge Clk);

      // Write pending during reset: strobe is visible, bypass is not.
      to_low_phase();
      WBregwrite = 1; WBRegDst = 5; WBAluResult = 32'h0000_0111; ReadRegister1 = 5;
      #1;
      check("rst_wren_ungated", {31'b0, WriteEn}, 32'd1);
      check("rst_bypass_suppressed", ReadData1, 32'd0);
      check_count("rst_count", 32'd0);
      @(posedge Clk);
      to_low_phase();
      idle();
      Reset = 1;
      #1;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
         #1;
         check("post_reset_rd1", ReadData1, 32'd0);
         check("post_reset_rd2", ReadData2, 32'd0);
      end

      // ALU write with same-cycle bypass, then from storage.
      to_low_phase();
      WBregwrite = 1; WBRegDst = 5; WBAluResult = 32'd2047; ReadRegister1 = 5;
      #1;
      check("alu_bypass_rd1", ReadData1, 32'd2047);
      check("alu_writedata", WriteData, 32'd2047);
      check("alu_writereg", 32'(WriteReg), 32'd5);
      @(posedge Clk);
      to_low_phase();
      idle();
      #1;
      check("alu_wren_off", {31'b0, WriteEn}, 32'd0);
      check("alu_stored_rd1", ReadData1, 32'd2047);

      // Load data takes priority over ALU result.
      WBregwrite = 1; WBmemtoreg = 1; WBRegDst = 7; WBReadData = 32'd1023; WBAluResult = 32'd2047;
      #1;
      check("load_writedata", WriteData, 32'd1023);
      @(posedge Clk);
      to_low_phase();
      idle(); ReadRegister2 = 7;
      #1;
      check("load_stored_rd2", ReadData2, 32'd1023);

      // jal forces link register and commits without regwrite.
      WBcntrljald = 1; WBRegDst = 3; WBPCAddResult = 32'd4095; WBmemtoreg = 1; WBReadData = 32'd1;
      #1;
      check("jal_writereg", 32'(WriteReg), 32'd31);
      check("jal_wren", {31'b0, WriteEn}, 32'd1);
      check("jal_writedata", WriteData, 32'd4095);
      WBcntrljalr = 1;
      #1;
      check("jal_jalr_both_reg", 32'(WriteReg), 32'd31);
      WBcntrljalr = 0;
      @(posedge Clk);
      to_low_phase();
      idle(); ReadRegister1 = 31; ReadRegister2 = 3;
      #1;
      check("jal_stored_r31", ReadData1, 32'd4095);
      check("jal_r3_untouched", ReadData2, 32'd0);

      // jalr writes link address to its own destination.
      WBcntrljalr = 1; WBRegDst = 3; WBPCAddResult = 32'd4095; WBAluResult = 32'd9;
      #1;
      check("jalr_writereg", 32'(WriteReg), 32'd3);
      check("jalr_bypass_rd2", ReadData2, 32'd4095);
      @(posedge Clk);
      to_low_phase();
      idle();
      #1;
      check("jalr_stored_r3", ReadData2, 32'd4095);
      check_count("count_after_4", 32'd4);

      // Writes to register 0 are dropped.
      WBregwrite = 1; WBRegDst = 0; WBAluResult = 32'hDEAD_BEEF; ReadRegister1 = 0; ReadRegister2 = 0;
      #1;
      check("r0_wren", {31'b0, WriteEn}, 32'd0);
      check("r0_rd1_before", ReadData1, 32'd0);
      check("r0_rd2_before", ReadData2, 32'd0);
      @(posedge Clk);
      to_low_phase();
      idle();
      #1;
      check("r0_rd1_after", ReadData1, 32'd0);
      check("r0_rd2_after", ReadData2, 32'd0);
      check_count("r0_count", 32'd4);

      // Both ports bypass from one write.
      WBregwrite = 1; WBRegDst = 12; WBAluResult = 32'hA5A5_A5A5; ReadRegister1 = 12; ReadRegister2 = 12;
      #1;
      check("dual_bypass_rd1", ReadData1, 32'hA5A5_A5A5);
      check("dual_bypass_rd2", ReadData2, 32'hA5A5_A5A5);
      @(posedge Clk);
      to_low_phase();
      idle();
      check_count("dual_count", 32'd5);

      // Unknown destination with no strobe must not disturb storage.
      WBRegDst = 'x; WBAluResult = 32'hFFFF_FFFF; ReadRegister1 = 5; ReadRegister2 = 12;
      #1;
      check("x_dst_wren", {31'b0, WriteEn}, 32'd0);
      @(posedge Clk);
      to_low_phase();
      idle();
      #1;
      check("x_dst_r5", ReadData1, 32'd2047);
      check("x_dst_r12", ReadData2, 32'hA5A5_A5A5);
      check_count("x_dst_count", 32'd5);

      // Mid-cycle reset with a write pending to register 9.
      WBregwrite = 1; WBRegDst = 9; WBAluResult = 32'h1234_5678;
      @(posedge Clk);
      to_low_phase();
      WBAluResult = 32'hCAFE_F00D; ReadRegister1 = 9; ReadRegister2 = 5;
      #1;
      check("r9_bypass_pre_reset", ReadData1, 32'hCAFE_F00D);
      Reset = 0;
      #1;
      check("r9_async_clear", ReadData1, 32'd0);
      check("r5_async_clear", ReadData2, 32'd0);
      check_count("reset_count", 32'd0);
      @(posedge Clk);
      to_low_phase();
      idle();
      Reset = 1;
      #1;
      check("r9_after_release", ReadData1, 32'd0);
      check_count("release_count", 32'd0);

      // First commit after release lands on the next edge.
      WBregwrite = 1; WBRegDst = 9; WBAluResult = 32'h0000_0001;
      @(posedge Clk);
      to_low_phase();
      idle();
      #1;
      check("r9_first_commit", ReadData1, 32'd1);
      check_count("first_commit_count", 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Writeback-side consumer of the MEM/WB pipeline register.
- Takes the WB-stage control and data fields.
- Selects the write-back value (ALU result, load data, or link address) and commits it to a 32x32 general-purpose register file.
- Serves the two ID-stage read ports, with same-cycle write-through bypass so an ID read never sees stale data for a register being written back.

Parameters:
- DATA_W, 32, register/data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, register count. Must equal 2**ADDR_W.
- LINK_REG, 31, destination index forced for jal.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; clears the register file.
- WBmemtoreg  input  1  select load data as write value.
- WBregwrite  input  1  write enable from pipeline.
- WBcntrljalr  input  1  jalr in WB: write link address to WBRegDst.
- WBcntrljald  input  1  jal in WB: write link address to LINK_REG.
- WBPCAddResult  input  DATA_W  link address (already PC-incremented upstream).
- WBAluResult  input  DATA_W  ALU result.
- WBReadData  input  DATA_W  data memory load result.
- WBRegDst  input  ADDR_W  destination register index.
- ReadRegister1  input  ADDR_W  ID read port 1 index.
- ReadRegister2  input  ADDR_W  ID read port 2 index.
- ReadData1  output  DATA_W  port 1 data (combinational).
- ReadData2  output  DATA_W  port 2 data (combinational).
- WriteData  output  DATA_W  selected write-back value (combinational, for forwarding unit).
- WriteReg  output  ADDR_W  effective destination index (combinational).
- WriteEn  output  1  effective write strobe this cycle (combinational).

Behaviour:
- **Write value select, priority order:**
  - WBcntrljald or WBcntrljalr -> WBPCAddResult.
  - else WBmemtoreg -> WBReadData.
  - else WBAluResult.
- **Effective destination:** WriteReg = LINK_REG if WBcntrljald, else WBRegDst. If jald and jalr are both high, jald wins.
- **Effective strobe:** WriteEn = (WBregwrite | WBcntrljald | WBcntrljalr) & (WriteReg != 0).
  - jal/jalr commit even if WBregwrite is low.
  - Writes to register 0 are always dropped.
- **Commit:** on rising Clk with Reset high and WriteEn = 1, regs[WriteReg] <= WriteData. Latency 1 cycle into storage; 0 cycles visible on the read ports via bypass.
- **Read ports:** ReadDataN =
  - 0 if ReadRegisterN == 0;
  - else WriteData if WriteEn and WriteReg == ReadRegisterN (bypass);
  - else regs[ReadRegisterN].
  - Both ports may bypass simultaneously from the same write.
- **Register 0:** never stored; always reads 0 regardless of any prior write attempt.
- **Reset:**
  - Reset low asynchronously clears all registers to 0 immediately, without waiting for a clock.
  - While Reset is low: no writes commit, and ReadData1/2 return 0 for every index. Bypass is also suppressed during reset.
  - Reset asserted mid-cycle with WriteEn high: the write is lost.
  - First commit is at the first rising edge after Reset deasserts.
- **Outputs at reset:** ReadData1 = ReadData2 = 0. WriteData, WriteReg and WriteEn are pure functions of the inputs and are not gated by Reset.
- **Unknown inputs:** X on WBRegDst while WriteEn is low must not corrupt any register.

Optional Feature:
- **Macro:** WB_REGFILE_WRCOUNT_EN.
- **Defined:**
  - Adds output WriteCount (32 bits).
  - Increments by 1 on each rising edge where a write commits (Reset high, WriteEn = 1).
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared to 0 asynchronously by Reset low.
  - Dropped writes to register 0 do not count.
- **Undefined:** port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low for 2 cycles, then high; read all 32 indices on both ports -> every read returns 0.
- WBregwrite=1, WBmemtoreg=0, WBRegDst=5, WBAluResult=2047; ReadRegister1=5 in the same cycle -> ReadData1=2047 via bypass. After the edge, with WriteEn=0, ReadData1=2047 from storage.
- WBregwrite=1, WBmemtoreg=1, WBRegDst=7, WBReadData=1023, WBAluResult=2047 -> WriteData=1023; regs[7]=1023 after the edge.
- WBcntrljald=1, WBregwrite=0, WBRegDst=3, WBPCAddResult=4095 -> WriteReg=31, WriteEn=1; regs[31]=4095 and regs[3] unchanged. Repeat with WBcntrljalr=1, WBRegDst=3 -> regs[3]=4095.
- WBregwrite=1, WBRegDst=0, WBAluResult=0xDEADBEEF; ReadRegister1=ReadRegister2=0 -> WriteEn=0; both reads return 0 before and after the edge. With WB_REGFILE_WRCOUNT_EN defined, WriteCount is unchanged.
- Write regs[9]=0x12345678, then pull Reset low mid-cycle with another write pending to 9 -> ReadData for index 9 is 0 immediately, stays 0 after Reset releases, and WriteCount=0.
